// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants for the camera pixel capture block
package cam_pkg;

  localparam int RGB565_W = 16;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SYNC       = 2'd1;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd2;
  localparam logic [1:0] ST_ACTIVE     = 2'd3;

endpackage

// File: rtl/cam_byte_pack.sv
// rtl/cam_byte_pack.sv - pairs camera bytes into RGB565 pixels and holds them in a
// single-entry output register with drop-on-full overflow tracking
module cam_byte_pack
  import cam_pkg::*;
#(
  parameter int COL_BITS = 10,
  parameter int ROW_BITS = 9
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                byte_en,
  input  logic                line_clr,
  input  logic [7:0]          byte_dat,
  input  logic                keep,
  input  logic                sof_in,
  input  logic [COL_BITS-1:0] col_in,
  input  logic [ROW_BITS-1:0] row_in,
  input  logic                pix_ready,
  input  logic                ovf_clr,
  output logic                pair_done,
  output logic [RGB565_W-1:0] pix_data,
  output logic                pix_valid,
  output logic                pix_sof,
  output logic [COL_BITS-1:0] pix_col,
  output logic [ROW_BITS-1:0] pix_row,
  output logic                overflow
);

  logic       phase;
  logic [7:0] hi_byte;
  logic       load;
  logic       slot_free;

  assign pair_done = byte_en && phase;
  assign load      = pair_done && keep;
  // a transfer in the same cycle frees the slot for the incoming pixel
  assign slot_free = !pix_valid || pix_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase   <= 1'b0;
      hi_byte <= '0;
    end else if (line_clr) begin
      phase <= 1'b0;
    end else if (byte_en) begin
      phase <= !phase;
      if (!phase) hi_byte <= byte_dat;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_col   <= '0;
      pix_row   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load && slot_free) begin
        pix_data  <= {hi_byte, byte_dat};
        pix_valid <= 1'b1;
        pix_sof   <= sof_in;
        pix_col   <= col_in;
        pix_row   <= row_in;
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end
      // a fresh drop wins over a same-cycle clear
      if (load && !slot_free) overflow <= 1'b1;
      else if (ovf_clr)       overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - DVP camera capture: frame FSM and pixel counters;
// CAM_PIXEL_DECIMATE_EN selects 2x2 decimated output
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int COL_BITS = 10,
  parameter int ROW_BITS = 9
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cap_en,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_dat,
  output logic [RGB565_W-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_sof,
  output logic [COL_BITS-1:0] pix_col,
  output logic [ROW_BITS-1:0] pix_row,
  output logic                frame_done,
  output logic                overflow,
  input  logic                ovf_clr
);

  logic                rv, rh, rv_q, rh_q;
  logic [7:0]          rd;
  logic [1:0]          state, state_nxt;
  logic [COL_BITS-1:0] col, col_out;
  logic [ROW_BITS-1:0] row, row_out;
  logic                sof_pending;
  logic                keep, pair_done;
  logic                rv_rise, rv_fall, rh_fall;
  logic                active, byte_en, line_end, frame_start;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv   <= 1'b0;
      rh   <= 1'b0;
      rd   <= '0;
      rv_q <= 1'b0;
      rh_q <= 1'b0;
    end else begin
      rv   <= cam_vsync;
      rh   <= cam_href;
      rd   <= cam_dat;
      rv_q <= rv;
      rh_q <= rh;
    end
  end

  assign rv_rise     = rv && !rv_q;
  assign rv_fall     = !rv && rv_q;
  assign rh_fall     = !rh && rh_q;
  assign active      = (state == ST_ACTIVE);
  assign byte_en     = active && rh;
  assign line_end    = active && rh_fall;
  assign frame_start = (state == ST_WAIT_FRAME) && rv_fall && cap_en;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       state_nxt = ST_SYNC;
      ST_SYNC:       if (rv_rise) state_nxt = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (rv_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE:     if (rv_rise) state_nxt = ST_WAIT_FRAME;
      default:       state_nxt = ST_IDLE;
    endcase
    if (!cap_en) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      sof_pending <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= active && rv_rise && cap_en;
      if (frame_start) begin
        col         <= '0;
        row         <= '0;
        sof_pending <= 1'b1;
      end else if (line_end) begin
        col <= '0;
        if (row != '1) row <= row + ROW_BITS'(1);
      end else if (pair_done) begin
        col <= col + COL_BITS'(1);
        if (keep) sof_pending <= 1'b0;
      end
    end
  end

`ifdef CAM_PIXEL_DECIMATE_EN
  assign keep    = !col[0] && !row[0];
  assign col_out = {1'b0, col[COL_BITS-1:1]};
  assign row_out = {1'b0, row[ROW_BITS-1:1]};
`else
  assign keep    = 1'b1;
  assign col_out = col;
  assign row_out = row;
`endif

  cam_byte_pack #(
    .COL_BITS(COL_BITS),
    .ROW_BITS(ROW_BITS)
  ) u_pack (
    .clk       (clk),
    .resetn    (resetn),
    .byte_en   (byte_en),
    .line_clr  (line_end || frame_start),
    .byte_dat  (rd),
    .keep      (keep),
    .sof_in    (sof_pending),
    .col_in    (col_out),
    .row_in    (row_out),
    .pix_ready (pix_ready),
    .ovf_clr   (ovf_clr),
    .pair_done (pair_done),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_col   (pix_col),
    .pix_row   (pix_row),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - randomized self-checking bench for cam_pixel_capture
module tb_cam_pixel_capture;

  localparam int CB = 10;
  localparam int RB = 9;

  logic          clk = 1'b0;
  logic          resetn, cap_en, cam_vsync, cam_href, pix_ready, ovf_clr;
  logic [7:0]    cam_dat;
  logic [15:0]   pix_data;
  logic          pix_valid, pix_sof, frame_done, overflow;
  logic [CB-1:0] pix_col;
  logic [RB-1:0] pix_row;

  typedef struct packed {
    logic [15:0]   d;
    logic          sof;
    logic [CB-1:0] c;
    logic [RB-1:0] r;
  } pix_t;

  int   errors = 0;
  int   checks = 0;
  int   fd_cnt = 0;
  int   fd_before;
  pix_t got_q[$];
  pix_t exp_q[$];
  logic [7:0] fb [0:7][0:15];
  int   ll [0:7];
  int   nl;

  always #5 clk = ~clk;

  cam_pixel_capture #(.COL_BITS(CB), .ROW_BITS(RB)) dut (
    .clk(clk), .resetn(resetn), .cap_en(cap_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_dat(cam_dat), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_col(pix_col), .pix_row(pix_row), .frame_done(frame_done),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always @(negedge clk) begin
    if (resetn && pix_valid && pix_ready) got_q.push_back({pix_data, pix_sof, pix_col, pix_row});
    if (frame_done) fd_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1;
    ticks(3);
    cam_vsync = 1'b0;
    ticks(3);
  endtask

  task automatic drive_line(input int l);
    cam_href = 1'b1;
    for (int i = 0; i < ll[l]; i++) begin
      cam_dat = fb[l][i];
      tick();
    end
    cam_href = 1'b0;
    cam_dat  = 8'h00;
    ticks(3 + int'($urandom_range(0, 2)));
  endtask

  task automatic drive_frame();
    vs_pulse();
    for (int l = 0; l < nl; l++) drive_line(l);
    fd_before = fd_cnt;
    vs_pulse();
  endtask

  task automatic fill_frame(input int lines, input int lo, input int hi);
    nl = lines;
    for (int l = 0; l < lines; l++) begin
      ll[l] = int'($urandom_range(lo, hi));
      for (int i = 0; i < 16; i++) fb[l][i] = 8'($urandom);
    end
  endtask

  // reference: every complete byte pair of every line is a pixel at (pair index, line index)
  function automatic void build_expected();
    bit first = 1'b1;
    pix_t p;
    exp_q.delete();
    for (int l = 0; l < nl; l++) begin
      for (int j = 0; j < ll[l] / 2; j++) begin
`ifdef CAM_PIXEL_DECIMATE_EN
        if ((j % 2) != 0 || (l % 2) != 0) continue;
        p.c = CB'(j / 2);
        p.r = RB'(l / 2);
`else
        p.c = CB'(j);
        p.r = RB'(l);
`endif
        p.d   = {fb[l][2*j], fb[l][2*j+1]};
        p.sof = first;
        first = 1'b0;
        exp_q.push_back(p);
      end
    end
  endfunction

  task automatic test_reset();
    resetn = 1'b0; cap_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_dat = 8'h00; pix_ready = 1'b0; ovf_clr = 1'b0;
    ticks(3);
    checks++; if (pix_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
    checks++; if (pix_data !== 16'h0)   begin errors++; $display("FAIL reset_data: got %h want 0", pix_data); end
    checks++; if (pix_sof !== 1'b0)     begin errors++; $display("FAIL reset_sof: got %b want 0", pix_sof); end
    checks++; if (pix_col !== '0)       begin errors++; $display("FAIL reset_col: got %0d want 0", pix_col); end
    checks++; if (pix_row !== '0)       begin errors++; $display("FAIL reset_row: got %0d want 0", pix_row); end
    checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int fd_start;
    cap_en = 1'b1; pix_ready = 1'b1;
    tick();
    nl = 2;
    for (int l = 0; l < 2; l++) begin
      ll[l] = 8;
      for (int i = 0; i < 8; i++) fb[l][i] = 8'(8'h12 + 8'h22 * (l * 8 + i));
    end
    build_expected();
    got_q.delete();
    fd_start = fd_cnt;
    drive_frame();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_pix%0d: got d=%h sof=%b col=%0d row=%0d want d=%h sof=%b col=%0d row=%0d", i,
                 got_q[i].d, got_q[i].sof, got_q[i].c, got_q[i].r, exp_q[i].d, exp_q[i].sof, exp_q[i].c, exp_q[i].r);
      end
    end
    checks++; if (fd_before != fd_start) begin errors++; $display("FAIL early_frame_done: got %0d pulses want 0", fd_before - fd_start); end
    checks++; if (fd_cnt - fd_before != 1) begin errors++; $display("FAIL frame_done_pulse: got %0d pulses want 1", fd_cnt - fd_before); end
  endtask

  task automatic test_odd_line();
    nl = 2; ll[0] = 7; ll[1] = 4;
    for (int l = 0; l < 2; l++) for (int i = 0; i < 16; i++) fb[l][i] = 8'($urandom);
    build_expected();
    got_q.delete();
    drive_frame();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL odd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL odd_pix%0d: got d=%h col=%0d row=%0d want d=%h col=%0d row=%0d", i,
                 got_q[i].d, got_q[i].c, got_q[i].r, exp_q[i].d, exp_q[i].c, exp_q[i].r);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      fill_frame(int'($urandom_range(1, 6)), 1, 15);
      build_expected();
      got_q.delete();
      drive_frame();
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_pix%0d: got d=%h sof=%b col=%0d row=%0d want d=%h sof=%b col=%0d row=%0d", f, i,
                   got_q[i].d, got_q[i].sof, got_q[i].c, got_q[i].r, exp_q[i].d, exp_q[i].sof, exp_q[i].c, exp_q[i].r);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [0:3];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    vs_pulse();
    got_q.delete();
    pix_ready = 1'b0;
    cam_href = 1'b1;
    for (int i = 0; i < 4; i++) begin cam_dat = b[i]; tick(); end
    cam_href = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_set: got %b want 1", overflow); end
    ticks(2);
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid: got %b want 1", pix_valid); end
    checks++; if (pix_data !== {b[0], b[1]}) begin errors++; $display("FAIL bp_held_data: got %h want %h", pix_data, {b[0], b[1]}); end
    checks++; if (pix_col !== '0) begin errors++; $display("FAIL bp_held_col: got %0d want 0", pix_col); end
    pix_ready = 1'b1;
    tick();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid %b want 0", pix_valid); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_transfers: got %0d want 1", got_q.size()); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr: got %b want 0", overflow); end
    ticks(2);
    // clear held high across a new drop: the drop must still register
    pix_ready = 1'b0; ovf_clr = 1'b1;
    cam_href = 1'b1;
    for (int i = 0; i < 4; i++) begin cam_dat = 8'($urandom); tick(); end
    cam_href = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_clr_vs_set: got %b want 1", overflow); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clr_after: got %b want 0", overflow); end
    ovf_clr = 1'b0; pix_ready = 1'b1;
    ticks(3);
  endtask

  task automatic test_midframe_enable();
    cap_en = 1'b0;
    ticks(2);
    fill_frame(2, 8, 8);
    got_q.delete();
    vs_pulse();
    cam_href = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) cap_en = 1'b1;
      cam_dat = fb[0][i];
      tick();
    end
    cam_href = 1'b0;
    ticks(3);
    drive_line(1);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL en_midframe_leak: got %0d pixels want 0", got_q.size()); end
    build_expected();
    drive_frame();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL en_next_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL en_pix%0d: got d=%h want d=%h", i, got_q[i].d, exp_q[i].d); end
    end
  endtask

  task automatic test_reset_midline();
    cap_en = 1'b1; pix_ready = 1'b1;
    fill_frame(2, 8, 8);
    vs_pulse();
    got_q.delete();
    pix_ready = 1'b0;
    cam_href = 1'b1;
    for (int i = 0; i < 3; i++) begin cam_dat = fb[0][i]; tick(); end
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", pix_valid); end
    resetn = 1'b0;
    #1;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", pix_valid); end
    checks++; if (pix_data !== 16'h0) begin errors++; $display("FAIL rst_async_data: got %h want 0", pix_data); end
    tick();
    resetn = 1'b1; pix_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin cam_dat = fb[0][i]; tick(); end
    cam_href = 1'b0;
    ticks(3);
    drive_line(1);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_resume_early: got %0d pixels want 0", got_q.size()); end
    build_expected();
    drive_frame();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_next_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_pix%0d: got d=%h want d=%h", i, got_q[i].d, exp_q[i].d); end
    end
  endtask

`ifdef CAM_PIXEL_DECIMATE_EN
  task automatic test_decimate();
    int want_c [0:3];
    int want_r [0:3];
    want_c = '{0, 1, 0, 1};
    want_r = '{0, 0, 1, 1};
    fill_frame(4, 8, 8);
    build_expected();
    got_q.delete();
    drive_frame();
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL dec_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (int'(got_q[i].c) != want_c[i] || int'(got_q[i].r) != want_r[i] || got_q[i].d !== exp_q[i].d) begin
        errors++;
        $display("FAIL dec_pix%0d: got d=%h col=%0d row=%0d want d=%h col=%0d row=%0d", i,
                 got_q[i].d, got_q[i].c, got_q[i].r, exp_q[i].d, want_c[i], want_r[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_odd_line();
    test_random_frames();
`ifdef CAM_PIXEL_DECIMATE_EN
    test_decimate();
`else
    test_backpressure();
`endif
    test_midframe_enable();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
